// File: rtl/reg_file_dump.sv
// Register file with 2^ADDR_WIDTH x DATA_WIDTH storage, two combinational read ports,
// one write port with write-to-read bypass, and a valid/ready engine that streams every register.
module reg_file_dump #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] i_r1,
  input  logic [ADDR_WIDTH-1:0] i_r2,
  output logic [DATA_WIDTH-1:0] d1,
  output logic [DATA_WIDTH-1:0] d2,
  input  logic                  regwrite,
  input  logic [ADDR_WIDTH-1:0] write_register,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  dump_start,
  output logic                  dump_busy,
  output logic                  dump_valid,
  input  logic                  dump_ready,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data,
  output logic                  dump_done
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_en;

  // A write to the hardwired-zero index is dropped entirely, so it never bypasses either.
  assign wr_en = regwrite && !(ZERO_REG && (write_register == '0));

  // Value of a register as it will be after the current edge (bypass included).
  function automatic logic [DATA_WIDTH-1:0] read_word(input logic [ADDR_WIDTH-1:0] idx);
    if (wr_en && (write_register == idx)) begin
      read_word = write_data;
    end else if (ZERO_REG && (idx == '0)) begin
      read_word = '0;
    end else begin
      read_word = mem_q[idx];
    end
  endfunction

  assign d1 = read_word(i_r1);
  assign d2 = read_word(i_r2);

  // Next array contents.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[write_register] = write_data;
    end else begin
      mem_d = mem_q;
    end
  end

  // Storage array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Dump engine next state; a captured word is held until the consumer takes it.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (dump_start) begin
          state_d = ST_SEND;
          addr_d  = '0;
          data_d  = read_word('0);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SEND: begin
        if (dump_ready) begin
          if (addr_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            addr_d = addr_q + ONE_IDX;
            data_d = read_word(addr_q + ONE_IDX);
          end
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Dump engine registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign dump_valid = (state_q == ST_SEND);
  assign dump_busy  = (state_q != ST_IDLE);
  assign dump_done  = (state_q == ST_DONE);
  assign dump_addr  = addr_q;
  assign dump_data  = data_q;

endmodule

// File: tb/tb_reg_file_dump.sv
// Self-checking bench for reg_file_dump: directed vector table, randomized traffic against
// an array reference model, and hand-written dump sequences (full, backpressure, reset abort).
module tb_reg_file_dump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  i_r1, i_r2, write_register, dump_addr;
  logic [31:0] d1, d2, write_data, dump_data;
  logic        regwrite, dump_start, dump_busy, dump_valid, dump_ready, dump_done;

  always #5 clk = ~clk;

  reg_file_dump #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .i_r1(i_r1), .i_r2(i_r2), .d1(d1), .d2(d2),
    .regwrite(regwrite), .write_register(write_register), .write_data(write_data),
    .dump_start(dump_start), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_done(dump_done)
  );

  // Reference model: register contents plus dump phase (0 idle, 1 sending, 2 done).
  logic [31:0] mdl [32];
  int          m_phase;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  int          errors = 0;
  int          checks = 0;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_read(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (regwrite && (write_register == a)) return write_data;
    return mdl[a];
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
    m_phase = 0;
    m_addr  = 5'd0;
    m_data  = 32'd0;
  endtask

  // One rising edge; the model absorbs the inputs present at that edge.
  task automatic tick();
    @(posedge clk);
    if (regwrite && (write_register != 5'd0)) mdl[write_register] = write_data;
    case (m_phase)
      0: if (dump_start) begin m_phase = 1; m_addr = 5'd0; m_data = 32'd0; end
      1: if (dump_ready) begin
           if (m_addr == 5'd31) m_phase = 2;
           else begin m_addr = m_addr + 5'd1; m_data = mdl[m_addr]; end
         end
      2: m_phase = 0;
      default: m_phase = 0;
    endcase
    #1;
  endtask

  task automatic chk_dump();
    chk("dump_valid", {31'd0, dump_valid}, {31'd0, m_phase == 1});
    chk("dump_busy", {31'd0, dump_busy}, {31'd0, m_phase != 0});
    chk("dump_done", {31'd0, dump_done}, {31'd0, m_phase == 2});
    if (m_phase == 1) begin
      chk("dump_addr", {27'd0, dump_addr}, {27'd0, m_addr});
      chk("dump_data", dump_data, m_data);
    end
  endtask

  task automatic chk_reads();
    chk("d1", d1, ref_read(i_r1));
    chk("d2", d2, ref_read(i_r2));
  endtask

  int valid_cnt, done_cnt, busy_cnt, xfers, guard;

  initial begin
    rst_n = 1'b0; regwrite = 1'b0; write_register = 5'd0; write_data = 32'd0;
    i_r1 = 5'd5; i_r2 = 5'd6; dump_start = 1'b0; dump_ready = 1'b0;
    clear_model();
    #12;
    chk("rst_valid", {31'd0, dump_valid}, 32'd0);
    chk("rst_busy", {31'd0, dump_busy}, 32'd0);
    chk("rst_done", {31'd0, dump_done}, 32'd0);
    chk("rst_addr", {27'd0, dump_addr}, 32'd0);
    chk("rst_data", dump_data, 32'd0);
    chk("rst_d1", d1, 32'd0);
    chk("rst_d2", d2, 32'd0);
    rst_n = 1'b1;

    // Directed vectors: write/read, bypass, zero register.
    vecs[0] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd6, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd6, 5'd0, 32'h0,        32'h0};
    vecs[2] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd7, 32'h12345678, 5'd7, 5'd6, 32'h12345678, 32'h0};
    vecs[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd7, 5'd0, 32'h12345678, 32'h0};
    vecs[5] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0};
    vecs[6] = '{1'b1, 5'd5, 32'h00000001, 5'd5, 5'd5, 32'h00000001, 32'h00000001};
    vecs[7] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd7, 32'h00000001, 32'h12345678};
    for (int v = 0; v < 8; v++) begin
      regwrite = vecs[v].we; write_register = vecs[v].wa; write_data = vecs[v].wd;
      i_r1 = vecs[v].r1; i_r2 = vecs[v].r2;
      #1;
      chk($sformatf("vec%0d_d1", v), d1, vecs[v].e1);
      chk($sformatf("vec%0d_d2", v), d2, vecs[v].e2);
      tick();
    end

    // Random read/write traffic with the dump engine idle.
    for (int n = 0; n < 150; n++) begin
      regwrite = 1'($urandom_range(0, 1));
      write_register = 5'($urandom);
      write_data = $urandom;
      i_r1 = ($urandom_range(0, 3) == 0) ? write_register : 5'($urandom);
      i_r2 = ($urandom_range(0, 3) == 0) ? write_register : 5'($urandom);
      #1;
      chk_reads();
      tick();
      chk_dump();
    end

    // Full dump with ready held high.
    for (int i = 0; i < 32; i++) begin
      regwrite = 1'b1; write_register = 5'(i); write_data = i * 32'h11;
      tick();
    end
    regwrite = 1'b0;
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    valid_cnt = 0; done_cnt = 0; busy_cnt = 0;
    for (int c = 0; c < 40; c++) begin
      chk_dump();
      if (dump_valid) valid_cnt++;
      if (dump_done) done_cnt++;
      if (dump_busy) busy_cnt++;
      tick();
    end
    chk("full_valid_cycles", valid_cnt, 32'd32);
    chk("full_done_pulses", done_cnt, 32'd1);
    chk("full_busy_cycles", busy_cnt, 32'd33);

    // Backpressure with writes, including to the presented register, and a stray start.
    xfers = 0;
    for (int c = 0; c < 100; c++) begin
      dump_ready = 1'(c % 2);
      dump_start = (c == 0 || c == 20);
      regwrite = 1'b1;
      if (m_phase == 1 && m_addr == 5'd3) begin
        write_register = 5'd3; write_data = 32'hA5A50000 + 32'(c);
      end else begin
        write_register = 5'($urandom); write_data = $urandom;
      end
      i_r1 = write_register; i_r2 = 5'($urandom);
      #1;
      chk_reads();
      if (dump_valid && dump_ready) xfers++;
      tick();
      chk_dump();
    end
    dump_start = 1'b0; regwrite = 1'b0;
    chk("bp_transfers", xfers, 32'd32);
    chk("bp_idle_after", {31'd0, dump_busy}, 32'd0);

    // Reset in the middle of a dump.
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    guard = 0;
    while (m_addr != 5'd10 && guard < 20) begin
      tick();
      guard++;
    end
    chk("abort_reached_10", {27'd0, dump_addr}, 32'd10);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, dump_valid}, 32'd0);
    chk("abort_busy", {31'd0, dump_busy}, 32'd0);
    chk("abort_done", {31'd0, dump_done}, 32'd0);
    chk("abort_addr", {27'd0, dump_addr}, 32'd0);
    chk("abort_data", dump_data, 32'd0);
    clear_model();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      i_r1 = 5'(i); i_r2 = 5'(31 - i);
      #1;
      chk_reads();
    end
    tick();
    chk_dump();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
